// File: rtl/avalon_pio_bidir_pkg.sv
// avalon_pio_pkg: register addresses and edge-capture mode encodings for avalon_pio_bidir.
package avalon_pio_pkg;
  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_DIR      = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK  = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP  = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/avalon_pio_bidir_if.sv
// avalon_pio_bidir_if: Avalon-MM slave bus (address, chipselect, write_n, read_n, writedata in; readdata out).
interface avalon_pio_bidir_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master (output address, chipselect, write_n, read_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, read_n, writedata, output readdata);
endinterface

// File: rtl/avalon_pio_bidir_sync_edge.sv
// pio_sync_edge: SYNC_STAGES-deep synchroniser plus edge detect; ports clk, reset_n, d_in (async), pin_s (synchronised), edge_p (one-cycle edge pulses).
module pio_sync_edge
  import avalon_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_ANY
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] pin_s,
  output logic [WIDTH-1:0] edge_p
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] pin_d_q;
  always_comb begin
    sync_d[0] = d_in;
    for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
    pin_s  = sync_q[SYNC_STAGES-1];
    edge_p = EDGE_TYPE == EDGE_RISE ? pin_s & ~pin_d_q :
             EDGE_TYPE == EDGE_FALL ? ~pin_s & pin_d_q : pin_s ^ pin_d_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync_q  <= '0;
      pin_d_q <= '0;
    end else begin
      sync_q  <= sync_d;
      pin_d_q <= pin_s;
    end
endmodule

// File: rtl/avalon_pio_bidir.sv
// avalon_pio_bidir: Avalon-MM bidirectional PIO; ports clk, reset_n, bus (slave), pad_in/pad_out/pad_oe, irq. Define OPEN_DRAIN_EN for open-drain pads.
module avalon_pio_bidir
  import avalon_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = EDGE_ANY
) (
  input  logic               clk,
  input  logic               reset_n,
  avalon_pio_bidir_if.slave  bus,
  input  logic [WIDTH-1:0]   pad_in,
  output logic [WIDTH-1:0]   pad_out,
  output logic [WIDTH-1:0]   pad_oe,
  output logic               irq
);
  logic [WIDTH-1:0] data_q, data_d, dir_q, dir_d, mask_q, mask_d, edgecap_q, edgecap_d;
  logic [WIDTH-1:0] pin_s, edge_p, wd, w1c;
  logic [31:0] readdata_q, readdata_d, rd_val;
  logic irq_q, irq_d, wr, rd;
  logic unused;
  pio_sync_edge #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .EDGE_TYPE(EDGE_TYPE)) u_sync (
    .clk(clk), .reset_n(reset_n), .d_in(pad_in), .pin_s(pin_s), .edge_p(edge_p)
  );
  assign unused = ^bus.writedata;
  always_comb begin
    wr = bus.chipselect & ~bus.write_n;
    rd = bus.chipselect & ~bus.read_n;
    wd = bus.writedata[WIDTH-1:0];
    data_d = !wr ? data_q :
             bus.address == ADDR_DATA     ? wd :
             bus.address == ADDR_OUTSET   ? data_q | wd :
             bus.address == ADDR_OUTCLEAR ? data_q & ~wd : data_q;
    dir_d  = wr && bus.address == ADDR_DIR ? wd : dir_q;
    mask_d = wr && bus.address == ADDR_IRQMASK ? wd : mask_q;
    w1c    = wr && bus.address == ADDR_EDGECAP ? wd : '0;
    // OR-ing the new edges after the clear lets a coincident edge win
    edgecap_d = (edgecap_q & ~w1c) | edge_p;
    irq_d  = |(edgecap_q & mask_q);
    rd_val = bus.address == ADDR_DATA    ? 32'(pin_s) :
             bus.address == ADDR_DIR     ? 32'(dir_q) :
             bus.address == ADDR_IRQMASK ? 32'(mask_q) :
             bus.address == ADDR_EDGECAP ? 32'(edgecap_q) : 32'd0;
    readdata_d = rd ? rd_val : readdata_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      data_q     <= RESET_VALUE;
      dir_q      <= '0;
      mask_q     <= '0;
      edgecap_q  <= '0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      data_q     <= data_d;
      dir_q      <= dir_d;
      mask_q     <= mask_d;
      edgecap_q  <= edgecap_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
    end
  assign bus.readdata = readdata_q;
  assign irq = irq_q;
`ifdef OPEN_DRAIN_EN
  // pins only ever pull low; a released pin floats to the external pull-up
  assign pad_out = '0;
  assign pad_oe  = dir_q & ~data_q;
`else
  assign pad_out = data_q;
  assign pad_oe  = dir_q;
`endif
endmodule
